stopwatch_ctrl: RTL

STOPWATCH_CTRL -- requirements
Module: stopwatch_ctrl

---
 rtl/stopwatch_ctrl_if.sv | 42 ++++
 rtl/stopwatch_ctrl.sv | 135 +++++++++++++
 2 files changed

// File: rtl/stopwatch_ctrl_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : stopwatch_ctrl_if                                             |
// | Purpose  : Bundles the stopwatch controller's button inputs, live counter |
// |            digits, counter-control outputs and display digits.           |
// | Ports    : master - environment side (drives buttons and live digits)    |
// |            slave  - controller side (drives tick, status and display)    |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
interface stopwatch_ctrl_if;
   logic       btn_ss;
   logic       btn_lap;
   logic       btn_rst;
   logic [3:0] live_ds;
   logic [3:0] live_sr;
   logic [3:0] live_sl;
   logic [3:0] live_mn;
   logic       tick;
   logic       cnt_clr_n;
   logic       running;
   logic       frozen;
   logic       ovf;
   logic [3:0] disp_ds;
   logic [3:0] disp_sr;
   logic [3:0] disp_sl;
   logic [3:0] disp_mn;

   modport master (
      output btn_ss, btn_lap, btn_rst,
      output live_ds, live_sr, live_sl, live_mn,
      input  tick, cnt_clr_n, running, frozen, ovf,
      input  disp_ds, disp_sr, disp_sl, disp_mn
   );

   modport slave (
      input  btn_ss, btn_lap, btn_rst,
      input  live_ds, live_sr, live_sl, live_mn,
      output tick, cnt_clr_n, running, frozen, ovf,
      output disp_ds, disp_sr, disp_sl, disp_mn
   );
endinterface
`default_nettype wire

// File: rtl/stopwatch_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : stopwatch_ctrl                                                |
// | Purpose  : Stopwatch control: button synchronisation and edge detection,|
// |            IDLE/RUN/LAP/STOP state machine, decisecond tick prescaler,  |
// |            lap capture with display mux, and full-scale overflow flag.   |
// | Ports    : clk  - system clock, rising edge                              |
// |            clr  - synchronous active-low reset                           |
// |            sw   - stopwatch_ctrl_if.slave: buttons, live digits in;      |
// |                   tick, cnt_clr_n, running, frozen, ovf, disp_* out      |
// | Params   : TICK_DIV - clk cycles per decisecond tick (2 .. 2^24)         |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module stopwatch_ctrl #(
   parameter int unsigned TICK_DIV = 10_000_000
) (
   input wire              clk,
   input wire              clr,
   stopwatch_ctrl_if.slave sw
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_LAP  = 2'd2,
      ST_STOP = 2'd3
   } state_t;

   localparam logic [23:0] c_last_count = 24'(TICK_DIV - 1);
   localparam int          c_ss         = 0;
   localparam int          c_lap        = 1;
   localparam int          c_rst        = 2;

   state_t      r_state;
   logic [23:0] r_presc;
   logic [2:0]  r_sync1;
   logic [2:0]  r_sync2;
   logic [2:0]  r_prev;
   logic [15:0] r_cap;
   logic        r_running;
   logic        r_frozen;
   logic        r_ovf;
   logic        r_cnt_clr_n;

   logic [2:0]  w_ev;
   logic [15:0] w_live;
   logic        w_full;
   logic        w_active;
   logic        w_due;

   // One-cycle event per button press (bit order: rst, lap, ss).
   assign w_ev     = r_sync2 & ~r_prev;
   assign w_live   = {sw.live_mn, sw.live_sl, sw.live_sr, sw.live_ds};
   assign w_full   = (w_live == 16'h9599);
   assign w_active = (r_state == ST_RUN) || (r_state == ST_LAP);
   // A tick is "due" when the prescaler sits at its last count while counting;
   // at full scale it is swallowed and turns into an overflow stop instead.
   assign w_due    = w_active && (r_presc == c_last_count);

   assign sw.tick      = w_due && !w_full;
   assign sw.cnt_clr_n = r_cnt_clr_n;
   assign sw.running   = r_running;
   assign sw.frozen    = r_frozen;
   assign sw.ovf       = r_ovf;
   assign {sw.disp_mn, sw.disp_sl, sw.disp_sr, sw.disp_ds} = r_frozen ? r_cap : w_live;

   always_ff @(posedge clk) begin
      if (!clr) begin
         r_state     <= ST_IDLE;
         r_presc     <= '0;
         r_sync1     <= '0;
         r_sync2     <= '0;
         r_prev      <= '0;
         r_cap       <= '0;
         r_running   <= 1'b0;
         r_frozen    <= 1'b0;
         r_ovf       <= 1'b0;
         r_cnt_clr_n <= 1'b0;
      end else begin
         r_sync1     <= {sw.btn_rst, sw.btn_lap, sw.btn_ss};
         r_sync2     <= r_sync1;
         r_prev      <= r_sync2;
         r_cnt_clr_n <= 1'b1;

         case (r_state)
            ST_IDLE: begin
               if (w_ev[c_ss]) begin
                  r_state   <= ST_RUN;
                  r_running <= 1'b1;
               end
            end

            ST_RUN, ST_LAP: begin
               if (w_due && w_full) begin
                  // Prescaler is left at its last count; only a zero clears it.
                  r_state   <= ST_STOP;
                  r_running <= 1'b0;
                  r_frozen  <= 1'b0;
                  r_ovf     <= 1'b1;
               end else begin
                  r_presc <= w_due ? 24'd0 : r_presc + 24'd1;
                  if (w_ev[c_ss]) begin
                     r_state   <= ST_STOP;
                     r_running <= 1'b0;
                     r_frozen  <= 1'b0;
                  end else if (w_ev[c_lap]) begin
                     r_state  <= ST_LAP;
                     r_frozen <= 1'b1;
                     r_cap    <= w_live;
                  end
               end
            end

            ST_STOP: begin
               // Prescaler holds here so a resume finishes the partial tick.
               if (w_ev[c_rst]) begin
                  r_state     <= ST_IDLE;
                  r_presc     <= '0;
                  r_cnt_clr_n <= 1'b0;
                  r_ovf       <= 1'b0;
               end else if (w_ev[c_ss] && !r_ovf) begin
                  r_state   <= ST_RUN;
                  r_running <= 1'b1;
               end
            end

            default: begin
               r_state <= ST_IDLE;
            end
         endcase
      end
   end

endmodule
`default_nettype wire
